// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin priority arbiter.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [CODE_W-1:0] c
  );
    return N_REQ'(1) << c;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner picker: lowest set bit of req,
// scanning upward from ptr with wrap-around.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] win,
  output logic              any
);

  logic [N_REQ-1:0]  rot;
  logic [CODE_W-1:0] off;

  // Doubling the vector lets one right shift act as a rotate.
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = CODE_W'(i);
    end
    any = |req;
    win = off + ptr;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// 8-way arbiter: registered one-hot grant held until
// release or hold timeout, optional round-robin pointer.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              timeout
);

  state_t              state, state_n;
  logic [CODE_W-1:0]   ptr, ptr_n;
  logic [CODE_W-1:0]   pick_ptr;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [N_REQ-1:0]    gnt_n;
  logic [CODE_W-1:0]   code_n;
  logic                valid_n;
  logic                timeout_n;
  logic [CODE_W-1:0]   win;
  logic                any;
  logic                rel;
  logic                expire;

  assign pick_ptr = (RR_EN != 0) ? ptr : '0;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (win),
    .any (any)
  );

  assign rel    = !req[code];
  assign expire = (MAX_HOLD != 0) && req[code] &&
                  (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    code_n    = code;
    valid_n   = valid;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = BUSY;
          gnt_n   = onehot(win);
          code_n  = win;
          valid_n = 1'b1;
          hold_n  = '0;
        end
      end
      BUSY: begin
        if (rel || expire) begin
          state_n   = IDLE;
          gnt_n     = '0;
          code_n    = '0;
          valid_n   = 1'b0;
          // Voluntary release wins over expiry.
          timeout_n = !rel;
          if (RR_EN != 0) ptr_n = code + CODE_W'(1);
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      code     <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      code     <= code_n;
      valid    <= valid_n;
      timeout  <= timeout_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt));
      assert (gnt == (valid ? onehot(code) : '0));
      if (state == IDLE && any) assert (req[win]);
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: fixed-priority vector table plus
// round-robin, timeout and mid-grant reset sequences.
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req_a   [4];
  logic [7:0] gnt_a   [4];
  logic [2:0] code_a  [4];
  logic       valid_a [4];
  logic       to_a    [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: RR, hold 16   1: fixed, hold 16
  // 2: RR, hold 4    3: fixed, hold 4
  rr_priority_arbiter #(.RR_EN(1), .MAX_HOLD(16), .HOLD_W(5)) d0 (
    .clk(clk), .rst(rst), .req(req_a[0]), .gnt(gnt_a[0]),
    .code(code_a[0]), .valid(valid_a[0]), .timeout(to_a[0]));
  rr_priority_arbiter #(.RR_EN(0), .MAX_HOLD(16), .HOLD_W(5)) d1 (
    .clk(clk), .rst(rst), .req(req_a[1]), .gnt(gnt_a[1]),
    .code(code_a[1]), .valid(valid_a[1]), .timeout(to_a[1]));
  rr_priority_arbiter #(.RR_EN(1), .MAX_HOLD(4), .HOLD_W(3)) d2 (
    .clk(clk), .rst(rst), .req(req_a[2]), .gnt(gnt_a[2]),
    .code(code_a[2]), .valid(valid_a[2]), .timeout(to_a[2]));
  rr_priority_arbiter #(.RR_EN(0), .MAX_HOLD(4), .HOLD_W(3)) d3 (
    .clk(clk), .rst(rst), .req(req_a[3]), .gnt(gnt_a[3]),
    .code(code_a[3]), .valid(valid_a[3]), .timeout(to_a[3]));

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] code;
    logic       v;
    logic       t;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic r, input logic [7:0] q,
                              input logic [7:0] g, input logic [2:0] c,
                              input logic v);
    vec_t x;
    x.rst = r; x.req = q; x.gnt = g; x.code = c; x.v = v; x.t = 1'b0;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d,
                     input logic [7:0] eg, input logic [2:0] ec,
                     input logic ev, input logic et);
    checks++;
    if (gnt_a[d] !== eg || code_a[d] !== ec ||
        valid_a[d] !== ev || to_a[d] !== et) begin
      errors++;
      $display("FAIL %s dut%0d: got gnt=%h code=%0d valid=%b timeout=%b, want gnt=%h code=%0d valid=%b timeout=%b",
               nm, d, gnt_a[d], code_a[d], valid_a[d], to_a[d],
               eg, ec, ev, et);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) req_a[i] = 8'h00;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_a[i] = 8'h00;

    tbl[0]  = mk(1, 8'hFF, 8'h00, 0, 0);
    tbl[1]  = mk(1, 8'hFF, 8'h00, 0, 0);
    tbl[2]  = mk(1, 8'hFF, 8'h00, 0, 0);
    tbl[3]  = mk(0, 8'hFF, 8'h01, 0, 1);
    tbl[4]  = mk(0, 8'h00, 8'h00, 0, 0);
    tbl[5]  = mk(0, 8'hA4, 8'h04, 2, 1);
    tbl[6]  = mk(0, 8'hA4, 8'h04, 2, 1);
    tbl[7]  = mk(0, 8'hA0, 8'h00, 0, 0);
    tbl[8]  = mk(0, 8'hA0, 8'h20, 5, 1);
    tbl[9]  = mk(0, 8'hA1, 8'h20, 5, 1);
    tbl[10] = mk(0, 8'h81, 8'h00, 0, 0);
    tbl[11] = mk(0, 8'h81, 8'h01, 0, 1);
    tbl[12] = mk(0, 8'h00, 8'h00, 0, 0);
    tbl[13] = mk(0, 8'h40, 8'h40, 6, 1);
    tbl[14] = mk(0, 8'h41, 8'h40, 6, 1);
    tbl[15] = mk(0, 8'h01, 8'h00, 0, 0);
    tbl[16] = mk(0, 8'h01, 8'h01, 0, 1);
    tbl[17] = mk(0, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst      = tbl[i].rst;
      req_a[1] = tbl[i].req;
      step();
      chk($sformatf("fixed_row%0d", i), 1, tbl[i].gnt,
          tbl[i].code, tbl[i].v, tbl[i].t);
    end

    // Round-robin rotation with wrap.
    do_reset();
    req_a[0] = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("rr_grant%0d", k), 0, 8'h01 << (k % 8),
          3'(k % 8), 1'b1, 1'b0);
      @(negedge clk);
      req_a[0] = 8'hFF & ~(8'h01 << (k % 8));
      step();
      chk($sformatf("rr_gap%0d", k), 0, 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      req_a[0] = 8'hFF;
      step();
    end

    // Hold timeout, RR and fixed side by side.
    do_reset();
    req_a[2] = 8'h03;
    req_a[3] = 8'h03;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("to_rr_hold%0d", c), 2, 8'h01, 3'd0, 1'b1, 1'b0);
      chk($sformatf("to_fx_hold%0d", c), 3, 8'h01, 3'd0, 1'b1, 1'b0);
    end
    step();
    chk("to_rr_pulse", 2, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("to_fx_pulse", 3, 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    chk("to_rr_next", 2, 8'h02, 3'd1, 1'b1, 1'b0);
    chk("to_fx_again", 3, 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    step();
    step();
    @(negedge clk);
    req_a[2] = 8'h00;
    step();
    chk("to_rr_vol_wins", 2, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("to_fx_pulse2", 3, 8'h00, 3'd0, 1'b0, 1'b1);

    // Reset mid-grant with a non-zero pointer.
    do_reset();
    req_a[0] = 8'h08;
    step();
    chk("mr_grant3a", 0, 8'h08, 3'd3, 1'b1, 1'b0);
    @(negedge clk);
    req_a[0] = 8'h00;
    step();
    chk("mr_release", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    req_a[0] = 8'h08;
    step();
    chk("mr_grant3b", 0, 8'h08, 3'd3, 1'b1, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    req_a[0] = 8'h09;
    step();
    chk("mr_drop", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mr_ptr0", 0, 8'h01, 3'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
